// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if
//   Bundle between the E-stage datapath/hazard unit (master) and the
//   multiply/divide unit (slave).
//
//   Command/handshake rules:
//     * start is a one-cycle command pulse qualified by md_op, rs_val and rt_val.
//       Operands and opcode are sampled only on the rising edge where start=1.
//     * A command is accepted only while busy=0. A start seen while busy=1 is
//       dropped without effect. Legal code never does this, because stall
//       holds the next HI/LO instruction in D.
//     * busy is registered. It is high for exactly the latency of the accepted
//       mult/div. mthi/mtlo never raise busy.
//     * stall = d_uses_md & (busy | start). It is combinational, so it covers
//       the start cycle itself.
//     * hi/lo are the architectural HI/LO registers and always reflect the
//       last committed value.
//
//   Signals:
//     start      master->slave  MDU op present in E
//     md_op[2:0] master->slave  0 mult,1 multu,2 div,3 divu,4 mthi,5 mtlo,6 madd,7 maddu
//     rs_val     master->slave  rs operand (dividend / multiplicand / mt source)
//     rt_val     master->slave  rt operand (divisor / multiplier)
//     d_uses_md  master->slave  D-stage instruction touches the MDU or HI/LO
//     busy       slave->master  multi-cycle op in flight
//     stall      slave->master  D-stage stall request
//     hi, lo     slave->master  architectural HI / LO
interface mult_div_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_uses_md;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, rs_val, rt_val, d_uses_md,
    input  busy, stall, hi, lo
  );

  modport slave (
    input  start, md_op, rs_val, rt_val, d_uses_md,
    output busy, stall, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   MIPS multiply/divide unit with HI/LO registers. The result is computed in a
//   single cycle at the start edge and parked in hi_p/lo_p. It is released into
//   HI/LO after a fixed latency, which models a multi-cycle iterative unit.
//   mthi/mtlo write HI/LO directly at the start edge.
//
//   Ports:
//     clk        system clock, rising edge
//     rst_n      asynchronous active-low reset
//     mdu        mult_div_unit_if.slave (start/md_op/operands in; busy/stall/hi/lo out)
//     state_dbg  current FSM state (0 IDLE, 1 RUN)
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  mult_div_unit_if.slave   mdu,
  output logic             state_dbg
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q;
  logic [31:0] hi_p_q, lo_p_q;
  logic        commit_q;
  logic [31:0] hi_q, lo_q;

  // ---------------- decode ----------------
  logic is_mul, is_div, is_mt, accept;
  logic op_signed;

  always_comb begin
    is_mul = (mdu.md_op == 3'd0) || (mdu.md_op == 3'd1) ||
             (mdu.md_op == 3'd6) || (mdu.md_op == 3'd7);
    is_div = (mdu.md_op == 3'd2) || (mdu.md_op == 3'd3);
    is_mt  = (mdu.md_op == 3'd4) || (mdu.md_op == 3'd5);
    // mult/madd/div are even opcodes; their unsigned forms set bit 0.
    op_signed = ~mdu.md_op[0];
    // Starts are only honoured from IDLE.
    accept = mdu.start && (state_q == IDLE);
  end

  // ---------------- multiply / multiply-accumulate ----------------
  logic [63:0] mul_a, mul_b, prod, mul_res;

  always_comb begin
    // Extending to 64 bits and keeping the low 64 product bits gives the exact
    // signed or unsigned 32x32 product.
    mul_a   = op_signed ? {{32{mdu.rs_val[31]}}, mdu.rs_val} : {32'b0, mdu.rs_val};
    mul_b   = op_signed ? {{32{mdu.rt_val[31]}}, mdu.rt_val} : {32'b0, mdu.rt_val};
    prod    = mul_a * mul_b;
    // madd/maddu (opcodes 6/7) accumulate onto current {HI,LO}, wrapping mod 2^64.
    mul_res = mdu.md_op[2] ? (prod + {hi_q, lo_q}) : prod;
  end

  // ---------------- divide ----------------
  logic        dvd_neg, dvs_neg, div_zero;
  logic [31:0] dvd_mag, dvs_mag, dvs_safe, uq, ur, quot, rem;

  always_comb begin
    dvd_neg  = op_signed & mdu.rs_val[31];
    dvs_neg  = op_signed & mdu.rt_val[31];
    dvd_mag  = dvd_neg ? (32'd0 - mdu.rs_val) : mdu.rs_val;
    dvs_mag  = dvs_neg ? (32'd0 - mdu.rt_val) : mdu.rt_val;
    div_zero = (mdu.rt_val == 32'd0);
    // A zero divisor never commits. Substituting 1 keeps the divider defined.
    dvs_safe = div_zero ? 32'd1 : dvs_mag;
    uq       = dvd_mag / dvs_safe;
    ur       = dvd_mag % dvs_safe;
    // Truncation toward zero: the quotient sign is the XOR of the operand signs
    // and the remainder follows the dividend. 0x80000000/-1 has magnitude
    // 0x80000000, which negates to itself, so it yields 0x80000000 with
    // remainder 0 without special handling.
    quot     = (dvd_neg ^ dvs_neg) ? (32'd0 - uq) : uq;
    rem      = dvd_neg ? (32'd0 - ur) : ur;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && (is_mul || is_div)) state_d = RUN;
      RUN:  if (cnt_q == 6'd0)                state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    mdu.busy  = (state_q == RUN);
    // Include start so that the instruction right behind a new MDU op is held
    // before busy has had a chance to rise.
    mdu.stall = mdu.d_uses_md & ((state_q == RUN) | mdu.start);
    state_dbg = state_q;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 6'd0;
      hi_p_q   <= 32'd0;
      lo_p_q   <= 32'd0;
      commit_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else if (accept && is_mul) begin
      hi_p_q   <= mul_res[63:32];
      lo_p_q   <= mul_res[31:0];
      commit_q <= 1'b1;
      cnt_q    <= MULT_LOAD;
    end else if (accept && is_div) begin
      hi_p_q   <= rem;
      lo_p_q   <= quot;
      commit_q <= ~div_zero;
      cnt_q    <= DIV_LOAD;
    end else if (accept && is_mt) begin
      if (mdu.md_op == 3'd4) hi_q <= mdu.rs_val;
      else                   lo_q <= mdu.rs_val;
    end else if (state_q == RUN) begin
      if (cnt_q == 6'd0) begin
        if (commit_q) begin
          hi_q <= hi_p_q;
          lo_q <= lo_p_q;
        end
      end else begin
        cnt_q <= cnt_q - 6'd1;
      end
    end
  end

  assign mdu.hi = hi_q;
  assign mdu.lo = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic rst_n;
  logic state_dbg;

  always #5 clk = ~clk;

  mult_div_unit_if bus();

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mdu       (bus.slave),
    .state_dbg (state_dbg)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] m_hilo;
  logic [63:0] exp_q[$];
  logic        last_start_stall;

  // Reference model of HI/LO after an op.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    int sa, sb, q, r;
    sa = a;
    sb = b;
    case (op)
      3'd0: return 64'(longint'(sa) * longint'(sb));
      3'd1: return {32'b0, a} * {32'b0, b};
      3'd2: begin
        if (b == 32'd0) return cur;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      3'd3: begin
        if (b == 32'd0) return cur;
        return {a % b, a / b};
      end
      3'd4: return {a, cur[31:0]};
      3'd5: return {cur[63:32], a};
      3'd6: return 64'(longint'(sa) * longint'(sb)) + cur;
      default: return ({32'b0, a} * {32'b0, b}) + cur;
    endcase
  endfunction

  function automatic int lat(input logic [2:0] op);
    if (op == 3'd2 || op == 3'd3) return 10;
    if (op == 3'd4 || op == 3'd5) return 0;
    return 5;
  endfunction

  // Called at a negedge. Drives a one-cycle start, returns at the negedge after
  // the start edge with the operands scrambled.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start  = 1'b1;
    bus.md_op  = op;
    bus.rs_val = a;
    bus.rt_val = b;
    m_hilo = model(op, a, b, m_hilo);
    exp_q.push_back(m_hilo);
    #1;
    last_start_stall = bus.stall;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.md_op  = 3'($urandom_range(0, 7));
    bus.rs_val = $urandom;
    bus.rt_val = $urandom;
  endtask

  // Counts busy cycles until idle, then compares the latency and the HI/LO
  // value popped from the scoreboard.
  task automatic wait_done(input int exp_cyc, input string name);
    int cyc;
    logic [63:0] e;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc !== exp_cyc) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, cyc, exp_cyc);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s hilo: got %h expected <empty queue>", name, {bus.hi, bus.lo});
    end else begin
      e = exp_q.pop_front();
      if ({bus.hi, bus.lo} !== e) begin
        errors++;
        $display("FAIL %s hilo: got %h expected %h", name, {bus.hi, bus.lo}, e);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, state_dbg, bus.hi, bus.lo} !== 66'd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b st=%b hi=%h lo=%h expected all 0",
               bus.busy, state_dbg, bus.hi, bus.lo);
    end
    rst_n = 1'b1;
    m_hilo = 64'd0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_div;
    start_op(3'd4, 32'hAAAA_5555, 32'd0);
    wait_done(0, "mthi_pre_reset");
    start_op(3'd5, 32'h1234_4321, 32'd0);
    wait_done(0, "mtlo_pre_reset");
    start_op(3'd2, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.hi, bus.lo} !== 65'd0) begin
      errors++;
      $display("FAIL reset_mid_div: got busy=%b hi=%h lo=%h expected 0/0/0",
               bus.busy, bus.hi, bus.lo);
    end
    exp_q.delete();
    m_hilo = 64'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) begin
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.hi, bus.lo} !== 65'd0) begin
        errors++;
        $display("FAIL post_reset_quiet: got busy=%b hi=%h lo=%h expected 0/0/0",
                 bus.busy, bus.hi, bus.lo);
      end
    end
  endtask

  task automatic test_mult;
    start_op(3'd0, 32'hFFFF_FFFF, 32'd2);
    wait_done(5, "mult");
    start_op(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_done(5, "multu");
    start_op(3'd0, 32'h8000_0000, 32'h8000_0000);
    wait_done(5, "mult_minmin");
  endtask

  task automatic test_div;
    start_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(10, "div_neg");
    start_op(3'd3, 32'd7, 32'd0);
    wait_done(10, "divu_zero");
    start_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(10, "div_overflow");
    start_op(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done(10, "divu");
  endtask

  task automatic test_madd;
    start_op(3'd4, 32'h1234_5678, 32'd0);
    wait_done(0, "mthi");
    start_op(3'd5, 32'd0, 32'd0);
    wait_done(0, "mtlo");
    start_op(3'd6, 32'd3, 32'd4);
    wait_done(5, "madd");
    start_op(3'd4, 32'd0, 32'd0);
    wait_done(0, "mthi0");
    start_op(3'd5, 32'hFFFF_FFFF, 32'd0);
    wait_done(0, "mtlo_ff");
    start_op(3'd7, 32'd1, 32'd1);
    wait_done(5, "maddu_carry");
    start_op(3'd6, 32'hFFFF_FFFF, 32'd1);
    wait_done(5, "madd_neg");
  endtask

  task automatic test_stall;
    int cyc;
    bus.d_uses_md = 1'b1;
    start_op(3'd0, 32'd5, 32'd6);
    checks++;
    if (last_start_stall !== 1'b1) begin
      errors++;
      $display("FAIL stall_start_cycle: got %b expected 1", last_start_stall);
    end
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 20) begin
      checks++;
      if (bus.stall !== 1'b1) begin
        errors++;
        $display("FAIL stall_busy: got %b expected 1 (cycle %0d)", bus.stall, cyc);
      end
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_idle: got %b expected 0", bus.stall);
    end
    wait_done(0, "stall_mult");
    bus.d_uses_md = 1'b0;
    start_op(3'd3, 32'd100, 32'd9);
    checks++;
    if (last_start_stall !== 1'b0) begin
      errors++;
      $display("FAIL nostall_start: got %b expected 0", last_start_stall);
    end
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 20) begin
      checks++;
      if (bus.stall !== 1'b0) begin
        errors++;
        $display("FAIL nostall_busy: got %b expected 0", bus.stall);
      end
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc !== 10) begin
      errors++;
      $display("FAIL nostall_latency: got %0d expected 10", cyc);
    end
    wait_done(0, "nostall_divu");
  endtask

  task automatic test_back_to_back;
    start_op(3'd0, 32'd1000, 32'hFFFF_FFFD);
    wait_done(5, "b2b_first");
    start_op(3'd1, 32'hDEAD_BEEF, 32'h0000_1234);
    wait_done(5, "b2b_second");
    // mtlo issued while a mult is still running must be dropped.
    start_op(3'd0, 32'd7, 32'd9);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.md_op  = 3'd5;
    bus.rs_val = 32'hCAFE_F00D;
    @(negedge clk);
    bus.start  = 1'b0;
    wait_done(3, "start_in_run_ignored");
  endtask

  task automatic test_random;
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      start_op(op, a, b);
      wait_done(lat(op), "random");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.start     = 1'b0;
    bus.md_op     = 3'd0;
    bus.rs_val    = 32'd0;
    bus.rt_val    = 32'd0;
    bus.d_uses_md = 1'b0;
    m_hilo        = 64'd0;
    last_start_stall = 1'b0;
    test_reset();
    test_reset_mid_div();
    test_mult();
    test_div();
    test_madd();
    test_stall();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
